vreg_loader: RTL and testbench
==============================

VREG_LOADER -- requirements
Module: vreg_loader

Interface
REQ-001 Parameter NUM_REGS, default 10, number of vector registers addressed.
REQ-002 Parameter LANES, default 6, bytes per vector register.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  load request; sampled only in IDLE.
REQ-007 base_addr  input  4  first destination register index.
REQ-008 count  input  4  number of vectors to load, 1..NUM_REGS.
REQ-009 abort  input  1  synchronous cancel of the load in progress.
REQ-010 in_valid  input  1  byte-stream data valid.
REQ-011 in_data  input  8  byte-stream data.
REQ-012 in_ready  output  1  loader accepts a byte this cycle.
REQ-013 WE3  output  1  register-file write strobe.
REQ-014 A3  output  4  register-file destination index.
REQ-015 WD3  output  LANES x 8  register-file write data, lane-packed.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 done  output  1  one-cycle pulse: load completed.
REQ-018 err  output  1  one-cycle pulse: start rejected.

Function
REQ-019 The FSM SHALL have states IDLE, COLLECT, WRITE, DONE.
REQ-020 In IDLE, start=1 with 1<=count and base_addr+count<=NUM_REGS SHALL latch base_addr and count and enter COLLECT next cycle with lane counter=0.
REQ-021 In IDLE, start=1 with count=0, base_addr>=NUM_REGS, or base_addr+count>NUM_REGS SHALL pulse err for one cycle and remain in IDLE; no write occurs.
REQ-022 Sums SHALL use 5-bit arithmetic; the range check SHALL NOT wrap.
REQ-023 in_ready SHALL be 1 only in COLLECT; a byte is accepted when in_valid=1 and in_ready=1.
REQ-024 The k-th accepted byte of a vector (k=0..LANES-1) SHALL be stored in lane k of the assembly buffer.
REQ-025 Acceptance of lane LANES-1 SHALL move the FSM to WRITE on the next edge.
REQ-026 In WRITE, WE3 SHALL be 1 for exactly one cycle, with A3=current address and WD3=assembly buffer; in_ready=0.
REQ-027 After WRITE, if vectors remain, the FSM SHALL return to COLLECT with address+1 and lane counter=0; otherwise it SHALL enter DONE.
REQ-028 DONE SHALL pulse done for one cycle, then return to IDLE.
REQ-029 Minimum load latency: WE3 asserts on the cycle after the 6th byte handshake; per-vector throughput SHALL be LANES+1 cycles.
REQ-030 WE3 SHALL be 0 in every state except WRITE; A3 and WD3 SHALL hold their last values outside WRITE.
REQ-031 start SHALL be ignored when busy=1.
REQ-032 abort=1 in COLLECT or WRITE SHALL return the FSM to IDLE next cycle, discard the partial vector, and suppress WE3 in that cycle, with no done pulse; already-written vectors remain written.
REQ-033 abort SHALL take priority over a simultaneous byte handshake or WRITE.
REQ-034 Gaps in in_valid SHALL stall collection indefinitely without loss of state.

Reset
REQ-035 rst_n=0 SHALL immediately force IDLE, with in_ready, WE3, busy, done and err at 0, A3=0, WD3=0, lane counter=0 and address=0.
REQ-036 Reset mid-load SHALL produce no further WE3; the partial vector is lost.

Verification
REQ-037 start, base_addr=2, count=1, bytes 11,22,33,44,55,66 -> one WE3 pulse with A3=2 and WD3 lanes 0..5 = 11..66; done pulse one cycle later.
REQ-038 base_addr=8, count=2, 12 bytes -> WE3 with A3=8, then WE3 with A3=9 seven cycles later; done; busy low afterwards.
REQ-039 base_addr=9, count=2; and separately count=0 -> err pulse, busy stays 0, WE3 never asserts.
REQ-040 in_valid toggled 1/0 every cycle during a count=1 load -> WE3 fires after the 6th accepted byte with correct lane order.
REQ-041 abort after 3 bytes of the second vector of a count=3 load -> exactly one WE3 (first address), IDLE next cycle, no done.
REQ-042 rst_n low for one cycle after 4 bytes -> all outputs 0 immediately; a new start then loads cleanly from lane 0.

Source files
------------

// File: rtl/vreg_loader_if.sv
// Handshake and register-file write bundle between a byte-stream source and vreg_loader.
// master drives the load controls and byte stream; slave is the loader itself.
interface vreg_loader_if #(
  parameter int LANES = 6
);
  logic                 start;
  logic [3:0]           base_addr;
  logic [3:0]           count;
  logic                 abort;
  logic                 in_valid;
  logic [7:0]           in_data;
  logic                 in_ready;
  logic                 WE3;
  logic [3:0]           A3;
  logic [LANES*8-1:0]   WD3;
  logic                 busy;
  logic                 done;
  logic                 err;

  modport master (
    output start, base_addr, count, abort, in_valid, in_data,
    input  in_ready, WE3, A3, WD3, busy, done, err
  );

  modport slave (
    input  start, base_addr, count, abort, in_valid, in_data,
    output in_ready, WE3, A3, WD3, busy, done, err
  );
endinterface

// File: rtl/vreg_loader.sv
// Assembles LANES-byte vectors from a byte stream and writes them to consecutive registers.
// One write per LANES accepted bytes; WE3 follows the last byte by one cycle; in_ready only while collecting.
module vreg_loader #(
  parameter int NUM_REGS = 10,
  parameter int LANES    = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  vreg_loader_if.slave  bus
);
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

  state_t               state_q, state_d;
  logic [3:0]           addr_q, addr_d;
  logic [3:0]           left_q, left_d;
  logic [LW-1:0]        lane_q, lane_d;
  logic [LANES*8-1:0]   buf_q, buf_d;
  logic [LANES*8-1:0]   wd3_q, wd3_d;
  logic [3:0]           a3_q, a3_d;
  logic                 err_q, err_d;
  logic [4:0]           end_addr;
  logic                 start_ok;

  // 5-bit sum so base_addr+count cannot wrap past the register count
  assign end_addr = {1'b0, bus.base_addr} + {1'b0, bus.count};
  assign start_ok = (bus.count != 4'd0) &&
                    ({1'b0, bus.base_addr} < 5'(NUM_REGS)) &&
                    (end_addr <= 5'(NUM_REGS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      left_q  <= '0;
      lane_q  <= '0;
      buf_q   <= '0;
      wd3_q   <= '0;
      a3_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      left_q  <= left_d;
      lane_q  <= lane_d;
      buf_q   <= buf_d;
      wd3_q   <= wd3_d;
      a3_q    <= a3_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    left_d  = left_q;
    lane_d  = lane_q;
    buf_d   = buf_q;
    wd3_d   = wd3_q;
    a3_d    = a3_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (start_ok) begin
            addr_d  = bus.base_addr;
            left_d  = bus.count;
            lane_d  = '0;
            state_d = COLLECT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (bus.abort) begin
          lane_d  = '0;
          state_d = IDLE;
        end else if (bus.in_valid) begin
          for (int k = 0; k < LANES; k++) begin
            if (lane_q == LW'(k)) buf_d[k*8 +: 8] = bus.in_data;
          end
          // Output registers are loaded here so A3/WD3 hold steady outside WRITE
          if (lane_q == LAST_LANE) begin
            lane_d  = '0;
            a3_d    = addr_q;
            wd3_d   = buf_d;
            state_d = WRITE;
          end else begin
            lane_d = lane_q + 1'b1;
          end
        end
      end
      WRITE: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (left_q == 4'd1) begin
          state_d = DONE;
        end else begin
          left_d  = left_q - 4'd1;
          addr_d  = addr_q + 4'd1;
          state_d = COLLECT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.in_ready = (state_q == COLLECT);
  assign bus.WE3      = (state_q == WRITE) && !bus.abort;
  assign bus.A3       = a3_q;
  assign bus.WD3      = wd3_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = (state_q == DONE);
  assign bus.err      = err_q;

endmodule

// File: tb/tb_vreg_loader.sv
// Randomized scoreboard bench for vreg_loader: expected writes/done/err events are queued
// at stimulus time and popped by a negedge monitor whenever the DUT presents one.
module tb_vreg_loader;
  localparam int NUM_REGS = 10;
  localparam int LANES    = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vreg_loader_if #(.LANES(LANES)) bus();

  vreg_loader #(.NUM_REGS(NUM_REGS), .LANES(LANES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int                 kind;   // 0 write, 1 done, 2 err
    logic [3:0]         addr;
    logic [LANES*8-1:0] data;
  } ev_t;

  ev_t        exp_q[$];
  int         we_log[$];
  logic [7:0] stim[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         last_hs_cyc = -100;
  int         last_we_cyc = -100;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pop_expect(input int kind, output ev_t ev, output bit ok);
    ok = 1'b0;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind %0d expected none (cycle %0d)", kind, cyc);
    end else begin
      ev = exp_q.pop_front();
      if (ev.kind != kind) begin
        errors++;
        $display("FAIL event_kind: got %0d expected %0d (cycle %0d)", kind, ev.kind, cyc);
      end else begin
        ok = 1'b1;
      end
    end
  endtask

  always @(negedge clk) begin
    ev_t ev;
    bit  ok;
    if (rst_n) begin
      if (bus.WE3) begin
        we_log.push_back(cyc);
        check("we_latency", 64'(cyc), 64'(last_hs_cyc + 1));
        pop_expect(0, ev, ok);
        if (ok) begin
          check("we_addr", 64'(bus.A3), 64'(ev.addr));
          check("we_data", 64'(bus.WD3), 64'(ev.data));
        end
        last_we_cyc = cyc;
      end
      if (bus.done) begin
        pop_expect(1, ev, ok);
        check("done_delay", 64'(cyc), 64'(last_we_cyc + 1));
      end
      if (bus.err) begin
        pop_expect(2, ev, ok);
        check("err_busy", 64'(bus.busy), 64'(0));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'(0));
    check({tag, "_we3"},      64'(bus.WE3),      64'(0));
    check({tag, "_busy"},     64'(bus.busy),     64'(0));
    check({tag, "_done"},     64'(bus.done),     64'(0));
    check({tag, "_err"},      64'(bus.err),      64'(0));
    check({tag, "_a3"},       64'(bus.A3),       64'(0));
    check({tag, "_wd3"},      64'(bus.WD3),      64'(0));
  endtask

  // gap_pct < 0 means in_valid alternates every cycle; abort_at < 0 means no abort
  task automatic load(input logic [3:0] b, input logic [3:0] c, input int gap_pct, input int abort_at);
    int   total, idx, guard, nvec, g2;
    bit   ok;
    ev_t  ev;
    ok    = (c != 0) && (int'(b) + int'(c) <= NUM_REGS);
    total = ok ? int'(c) * LANES : 0;
    while (stim.size() < total) stim.push_back(8'($urandom_range(255)));
    if (!ok) begin
      ev.kind = 2; ev.addr = '0; ev.data = '0;
      exp_q.push_back(ev);
    end else begin
      nvec = (abort_at < 0) ? int'(c) : abort_at / LANES;
      for (int v = 0; v < nvec; v++) begin
        ev.kind = 0;
        ev.addr = 4'(int'(b) + v);
        ev.data = '0;
        for (int k = 0; k < LANES; k++) ev.data[k*8 +: 8] = stim[v*LANES + k];
        exp_q.push_back(ev);
      end
      if (abort_at < 0) begin
        ev.kind = 1; ev.addr = '0; ev.data = '0;
        exp_q.push_back(ev);
      end
    end
    bus.start     = 1'b1;
    bus.base_addr = b;
    bus.count     = c;
    tick();
    bus.start = 1'b0;
    if (!ok) begin
      check("reject_busy", 64'(bus.busy), 64'(0));
      tick();
      tick();
      check("reject_busy_later", 64'(bus.busy), 64'(0));
      stim.delete();
      return;
    end
    check("busy_after_start", 64'(bus.busy), 64'(1));
    idx = 0;
    guard = 0;
    while (idx < total && guard < 5000) begin
      guard++;
      if (abort_at == idx && bus.in_ready) begin
        bus.abort    = 1'b1;
        bus.in_valid = 1'b0;
        tick();
        bus.abort = 1'b0;
        check("abort_idle", 64'(bus.busy), 64'(0));
        break;
      end
      if (gap_pct < 0) bus.in_valid = (cyc % 2) == 0;
      else             bus.in_valid = int'($urandom_range(99)) >= gap_pct;
      bus.in_data = stim[idx];
      if (bus.in_valid && bus.in_ready) begin
        last_hs_cyc = cyc;
        idx++;
      end
      tick();
    end
    bus.in_valid = 1'b0;
    if (guard >= 5000) begin
      errors++;
      $display("FAIL byte_budget: got %0d bytes expected %0d", idx, total);
    end
    g2 = 0;
    while (bus.busy && g2 < 100) begin
      g2++;
      tick();
    end
    check("busy_end", 64'(bus.busy), 64'(0));
    tick();
    stim.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.count     = '0;
    bus.abort     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    #1;
    check_all_zero("reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Single vector with known bytes
    stim = '{8'd11, 8'd22, 8'd33, 8'd44, 8'd55, 8'd66};
    load(4'd2, 4'd1, 0, -1);

    // Two vectors ending at the top register; writes seven cycles apart
    we_log.delete();
    load(4'd8, 4'd2, 0, -1);
    check("two_we_count", 64'(we_log.size()), 64'(2));
    if (we_log.size() == 2) check("we_spacing", 64'(we_log[1] - we_log[0]), 64'(7));

    // Rejected starts
    we_log.delete();
    load(4'd9, 4'd2, 0, -1);
    load(4'd3, 4'd0, 0, -1);
    load(4'd12, 4'd1, 0, -1);
    check("reject_no_we", 64'(we_log.size()), 64'(0));

    // Alternating in_valid
    stim = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    load(4'd0, 4'd1, -1, -1);

    // Abort after three bytes of the second vector
    we_log.delete();
    load(4'd1, 4'd3, 0, LANES + 3);
    check("abort_we_count", 64'(we_log.size()), 64'(1));

    // Reset in the middle of a vector
    bus.start = 1'b1; bus.base_addr = 4'd4; bus.count = 4'd2;
    tick();
    bus.start = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_data = 8'(8'hC0 + i);
      tick();
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    tick();
    rst_n = 1'b1;
    tick();
    stim = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    load(4'd5, 4'd1, 0, -1);

    // Random loads, some invalid, some with gaps or aborts
    for (int n = 0; n < 30; n++) begin
      logic [3:0] rb, rc;
      int ab, gp;
      rb = 4'($urandom_range(11));
      rc = 4'($urandom_range(10));
      gp = int'($urandom_range(50));
      ab = -1;
      if (rc != 0 && int'(rb) + int'(rc) <= NUM_REGS && $urandom_range(4) == 0)
        ab = int'($urandom_range(int'(rc) * LANES - 1));
      load(rb, rc, gp, ab);
    end

    tick();
    tick();
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
